// File: rtl/dphy_tx_lane_seq.sv
// D-PHY HS transmit sequencer for one data lane.
// Walks the lane through LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync (0xB8)
// -> payload -> HS-trail -> LP-11. All outputs are registered: the action
// chosen in cycle t (from state and inputs) appears on the outputs at t+1.
//
// Ports:
//   clk_i          byte clock
//   rst_n_i        asynchronous active-low reset
//   s_valid_i      payload byte valid / burst request when idle
//   s_data_i[7:0]  payload byte, bit 0 first on the wire
//   s_last_i       final byte of the packet
//   s_ready_o      payload byte accepted when s_valid_i & s_ready_o
//   hs_en_o        HS driver enable
//   hs_byte_o[7:0] byte to the LSB-first serializer
//   lp_o[1:0]      LP line state {Dp, Dn}
//   busy_o         high whenever not IDLE
//   packet_done_o  one-cycle pulse when the burst ends
//   underflow_o    one-cycle pulse when the payload stream is starved
module dphy_tx_lane_seq #(
   parameter int unsigned LP01_CYCLES   = 4,
   parameter int unsigned LP00_CYCLES   = 6,
   parameter int unsigned HS_ZERO_BYTES = 8,
   parameter int unsigned TRAIL_BYTES   = 4
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       s_valid_i,
   input  logic [7:0] s_data_i,
   input  logic       s_last_i,
   output logic       s_ready_o,
   output logic       hs_en_o,
   output logic [7:0] hs_byte_o,
   output logic [1:0] lp_o,
   output logic       busy_o,
   output logic       packet_done_o,
   output logic       underflow_o
);

   localparam int unsigned MAX_A = (LP01_CYCLES > LP00_CYCLES) ? LP01_CYCLES : LP00_CYCLES;
   localparam int unsigned MAX_B = (HS_ZERO_BYTES > TRAIL_BYTES) ? HS_ZERO_BYTES : TRAIL_BYTES;
   localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W = $clog2(MAX_P) + 1;

   localparam logic [7:0] SYNC_BYTE = 8'hB8;
   localparam logic [1:0] LP_11     = 2'b11;
   localparam logic [1:0] LP_01     = 2'b01;
   localparam logic [1:0] LP_00     = 2'b00;

   localparam logic [CNT_W-1:0] LD_LP01  = CNT_W'(LP01_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_LP00  = CNT_W'(LP00_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_ZERO  = CNT_W'(HS_ZERO_BYTES - 1);
   localparam logic [CNT_W-1:0] LD_TRAIL = CNT_W'(TRAIL_BYTES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      LP01,
      LP00,
      HS_ZERO,
      SYNC,
      PAYLOAD,
      TRAIL,
      EXIT
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_bit_q, last_bit_d;

   logic       ready_d;
   logic       hs_en_d;
   logic [7:0] hs_byte_d;
   logic [1:0] lp_d;
   logic       busy_d;
   logic       done_d;
   logic       underflow_d;

   logic       cnt_zero;
   logic [7:0] trail_byte;

   assign cnt_zero   = (cnt_q == '0);
   assign trail_byte = {8{~last_bit_q}};

   // State, counter and registered outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         last_bit_q    <= 1'b0;
         s_ready_o     <= 1'b0;
         hs_en_o       <= 1'b0;
         hs_byte_o     <= 8'h00;
         lp_o          <= LP_11;
         busy_o        <= 1'b0;
         packet_done_o <= 1'b0;
         underflow_o   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_bit_q    <= last_bit_d;
         s_ready_o     <= ready_d;
         hs_en_o       <= hs_en_d;
         hs_byte_o     <= hs_byte_d;
         lp_o          <= lp_d;
         busy_o        <= busy_d;
         packet_done_o <= done_d;
         underflow_o   <= underflow_d;
      end
   end

   // Next state and the action to present on the outputs next cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_bit_d  = last_bit_q;
      hs_en_d     = 1'b0;
      hs_byte_d   = 8'h00;
      lp_d        = LP_11;
      done_d      = 1'b0;
      underflow_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (s_valid_i) begin
               state_d = LP01;
               cnt_d   = LD_LP01;
               lp_d    = LP_01;
            end
         end

         LP01: begin
            if (cnt_zero) begin
               state_d = LP00;
               cnt_d   = LD_LP00;
               lp_d    = LP_00;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
               lp_d  = LP_01;
            end
         end

         LP00: begin
            lp_d = LP_00;
            if (cnt_zero) begin
               state_d = HS_ZERO;
               cnt_d   = LD_ZERO;
               hs_en_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         HS_ZERO: begin
            lp_d    = LP_00;
            hs_en_d = 1'b1;
            if (cnt_zero) begin
               state_d    = SYNC;
               hs_byte_d  = SYNC_BYTE;
               last_bit_d = SYNC_BYTE[7];
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         // s_ready_o is high in both; a missing byte cannot stall the lane.
         SYNC, PAYLOAD: begin
            lp_d    = LP_00;
            hs_en_d = 1'b1;
            if (s_valid_i) begin
               hs_byte_d  = s_data_i;
               last_bit_d = s_data_i[7];
               if (s_last_i) begin
                  state_d = TRAIL;
                  cnt_d   = LD_TRAIL;
               end else begin
                  state_d = PAYLOAD;
               end
            end else begin
               underflow_d = 1'b1;
               hs_byte_d   = trail_byte;
               state_d     = TRAIL;
               cnt_d       = LD_TRAIL;
            end
         end

         TRAIL: begin
            lp_d      = LP_00;
            hs_en_d   = 1'b1;
            hs_byte_d = trail_byte;
            if (cnt_zero) begin
               state_d = EXIT;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         EXIT: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == SYNC) || (state_d == PAYLOAD);
      busy_d  = (state_d != IDLE);
   end

endmodule

// File: tb/tb_dphy_tx_lane_seq.sv
// Directed bench for dphy_tx_lane_seq: per-cycle expectation tables plus
// hand-written reset and minimum-parameter sequences.
module tb_dphy_tx_lane_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_last;

   logic       a_ready, a_en, a_busy, a_done, a_unf;
   logic [7:0] a_byte;
   logic [1:0] a_lp;
   logic       b_ready, b_en, b_busy, b_done, b_unf;
   logic [7:0] b_byte;
   logic [1:0] b_lp;

   logic       sel_min;
   logic       o_ready, o_en, o_busy, o_done, o_unf;
   logic [7:0] o_byte;
   logic [1:0] o_lp;

   int n_cmp = 0;
   int n_bad = 0;

   dphy_tx_lane_seq dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .s_valid_i     (s_valid),
      .s_data_i      (s_data),
      .s_last_i      (s_last),
      .s_ready_o     (a_ready),
      .hs_en_o       (a_en),
      .hs_byte_o     (a_byte),
      .lp_o          (a_lp),
      .busy_o        (a_busy),
      .packet_done_o (a_done),
      .underflow_o   (a_unf)
   );

   dphy_tx_lane_seq #(
      .LP01_CYCLES   (1),
      .LP00_CYCLES   (1),
      .HS_ZERO_BYTES (1),
      .TRAIL_BYTES   (1)
   ) dut_min (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .s_valid_i     (s_valid),
      .s_data_i      (s_data),
      .s_last_i      (s_last),
      .s_ready_o     (b_ready),
      .hs_en_o       (b_en),
      .hs_byte_o     (b_byte),
      .lp_o          (b_lp),
      .busy_o        (b_busy),
      .packet_done_o (b_done),
      .underflow_o   (b_unf)
   );

   always_comb begin
      o_ready = sel_min ? b_ready : a_ready;
      o_en    = sel_min ? b_en    : a_en;
      o_byte  = sel_min ? b_byte  : a_byte;
      o_lp    = sel_min ? b_lp    : a_lp;
      o_busy  = sel_min ? b_busy  : a_busy;
      o_done  = sel_min ? b_done  : a_done;
      o_unf   = sel_min ? b_unf   : a_unf;
   end

   // One row covers cycles lo..hi: request enable in, expected outputs.
   typedef struct {
      int         lo;
      int         hi;
      logic       vld;
      logic [1:0] lp;
      logic       en;
      logic [7:0] byt;
      logic       rdy;
      logic       bsy;
      logic       done;
      logic       unf;
   } vec_t;

   vec_t       tbl[$];
   logic [7:0] q_data[$];
   logic       q_last[$];

   task automatic push(input int lo, input int hi, input int vld, input int lp, input int en,
                       input int byt, input int rdy, input int bsy, input int done, input int unf);
      vec_t v;
      v.lo = lo; v.hi = hi;
      v.vld = 1'(vld); v.lp = 2'(lp); v.en = 1'(en); v.byt = 8'(byt);
      v.rdy = 1'(rdy); v.bsy = 1'(bsy); v.done = 1'(done); v.unf = 1'(unf);
      tbl.push_back(v);
   endtask

   task automatic add_byte(input int d, input int last);
      q_data.push_back(8'(d));
      q_last.push_back(1'(last));
   endtask

   task automatic clear_all();
      tbl.delete();
      q_data.delete();
      q_last.delete();
   endtask

   // Default-parameter burst opening: request at off, sync byte at off+19.
   task automatic add_front(input int off, input int with_idle);
      if (with_idle != 0) push(off, off, 1, 3, 0, 0, 0, 0, 0, 0);
      push(off + 1,  off + 4,  1, 1, 0, 8'h00, 0, 1, 0, 0);
      push(off + 5,  off + 10, 1, 0, 0, 8'h00, 0, 1, 0, 0);
      push(off + 11, off + 18, 1, 0, 1, 8'h00, 0, 1, 0, 0);
      push(off + 19, off + 19, 1, 0, 1, 8'hB8, 1, 1, 0, 0);
   endtask

   task automatic check(input string nm, input int t, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, t, act, exp);
      end
   endtask

   task automatic check_reset(input string nm);
      check({nm, ".lp"},    0, 8'(o_lp),    8'h03);
      check({nm, ".en"},    0, 8'(o_en),    8'h00);
      check({nm, ".byte"},  0, o_byte,      8'h00);
      check({nm, ".ready"}, 0, 8'(o_ready), 8'h00);
      check({nm, ".busy"},  0, 8'(o_busy),  8'h00);
      check({nm, ".done"},  0, 8'(o_done),  8'h00);
      check({nm, ".unf"},   0, 8'(o_unf),   8'h00);
   endtask

   // Drives the byte queue with a valid/ready handshake and checks each cycle.
   task automatic run_seq(input string nm, input int ncyc);
      for (int t = 0; t < ncyc; t++) begin
         int k;
         k = -1;
         foreach (tbl[i]) if (k < 0 && t >= tbl[i].lo && t <= tbl[i].hi) k = i;
         @(posedge clk);
         #1;
         if (k >= 0 && tbl[k].vld && q_data.size() > 0) begin
            s_valid = 1'b1;
            s_data  = q_data[0];
            s_last  = q_last[0];
         end else begin
            s_valid = 1'b0;
            s_data  = 8'h00;
            s_last  = 1'b0;
         end
         @(negedge clk);
         if (k >= 0) begin
            check({nm, ".lp"},    t, 8'(o_lp),    8'(tbl[k].lp));
            check({nm, ".en"},    t, 8'(o_en),    8'(tbl[k].en));
            if (tbl[k].en) check({nm, ".byte"}, t, o_byte, tbl[k].byt);
            check({nm, ".ready"}, t, 8'(o_ready), 8'(tbl[k].rdy));
            check({nm, ".busy"},  t, 8'(o_busy),  8'(tbl[k].bsy));
            check({nm, ".done"},  t, 8'(o_done),  8'(tbl[k].done));
            check({nm, ".unf"},   t, 8'(o_unf),   8'(tbl[k].unf));
         end
         if (s_valid && o_ready) begin
            void'(q_data.pop_front());
            void'(q_last.pop_front());
         end
      end
   endtask

   // 3-byte packet 0x11 0x22 0x93(last), valid held from cycle 0.
   task automatic load_basic();
      clear_all();
      add_byte(8'h11, 0); add_byte(8'h22, 0); add_byte(8'h93, 1);
      add_front(0, 1);
      push(20, 20, 1, 0, 1, 8'h11, 1, 1, 0, 0);
      push(21, 21, 1, 0, 1, 8'h22, 1, 1, 0, 0);
      push(22, 22, 0, 0, 1, 8'h93, 0, 1, 0, 0);
      push(23, 26, 0, 0, 1, 8'h00, 0, 1, 0, 0);
      push(27, 27, 0, 3, 0, 8'h00, 0, 0, 1, 0);
      push(28, 30, 0, 3, 0, 8'h00, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;
      s_last  = 1'b0;
      sel_min = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("por");
      rst_n = 1'b1;

      load_basic();
      run_seq("basic", 31);

      // Last byte 0x7F: trail is all ones.
      clear_all();
      add_byte(8'hA5, 0); add_byte(8'h7F, 1);
      add_front(0, 1);
      push(20, 20, 1, 0, 1, 8'hA5, 1, 1, 0, 0);
      push(21, 21, 0, 0, 1, 8'h7F, 0, 1, 0, 0);
      push(22, 25, 0, 0, 1, 8'hFF, 0, 1, 0, 0);
      push(26, 26, 0, 3, 0, 8'h00, 0, 0, 1, 0);
      push(27, 28, 0, 3, 0, 8'h00, 0, 0, 0, 0);
      run_seq("trail_ff", 29);

      // Valid dropped after 2 of 5 bytes: one underflow pulse, trail from 0x82.
      clear_all();
      add_byte(8'h01, 0); add_byte(8'h82, 0); add_byte(8'h03, 0);
      add_byte(8'h04, 0); add_byte(8'h05, 1);
      add_front(0, 1);
      push(20, 20, 1, 0, 1, 8'h01, 1, 1, 0, 0);
      push(21, 21, 0, 0, 1, 8'h82, 1, 1, 0, 0);
      push(22, 22, 0, 0, 1, 8'h00, 0, 1, 0, 1);
      push(23, 26, 0, 0, 1, 8'h00, 0, 1, 0, 0);
      push(27, 27, 0, 3, 0, 8'h00, 0, 0, 1, 0);
      push(28, 29, 0, 3, 0, 8'h00, 0, 0, 0, 0);
      run_seq("underflow", 30);

      // Back-to-back requests: one IDLE cycle at 25, second burst shifted by 25.
      clear_all();
      add_byte(8'h11, 1); add_byte(8'h22, 1);
      add_front(0, 1);
      push(20, 20, 1, 0, 1, 8'h11, 0, 1, 0, 0);
      push(21, 24, 1, 0, 1, 8'hFF, 0, 1, 0, 0);
      push(25, 25, 1, 3, 0, 8'h00, 0, 0, 1, 0);
      add_front(25, 0);
      push(45, 45, 0, 0, 1, 8'h22, 0, 1, 0, 0);
      push(46, 49, 0, 0, 1, 8'hFF, 0, 1, 0, 0);
      push(50, 50, 0, 3, 0, 8'h00, 0, 0, 1, 0);
      push(51, 52, 0, 3, 0, 8'h00, 0, 0, 0, 0);
      run_seq("b2b", 53);

      // Asynchronous reset mid-payload, then a fresh packet.
      clear_all();
      add_byte(8'h31, 0); add_byte(8'h32, 0); add_byte(8'h33, 0);
      add_byte(8'h34, 0); add_byte(8'h35, 1);
      add_front(0, 1);
      push(20, 20, 1, 0, 1, 8'h31, 1, 1, 0, 0);
      push(21, 21, 1, 0, 1, 8'h32, 1, 1, 0, 0);
      run_seq("pre_rst", 22);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("async_rst");
      s_valid = 1'b0;
      s_data  = 8'h00;
      s_last  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset("rst_hold");
      #1;
      rst_n = 1'b1;
      load_basic();
      run_seq("post_rst", 31);

      // All parameters 1, single byte 0x00.
      sel_min = 1'b1;
      clear_all();
      add_byte(8'h00, 1);
      push(0, 0, 1, 3, 0, 8'h00, 0, 0, 0, 0);
      push(1, 1, 1, 1, 0, 8'h00, 0, 1, 0, 0);
      push(2, 2, 1, 0, 0, 8'h00, 0, 1, 0, 0);
      push(3, 3, 1, 0, 1, 8'h00, 0, 1, 0, 0);
      push(4, 4, 1, 0, 1, 8'hB8, 1, 1, 0, 0);
      push(5, 5, 0, 0, 1, 8'h00, 0, 1, 0, 0);
      push(6, 6, 0, 0, 1, 8'hFF, 0, 1, 0, 0);
      push(7, 7, 0, 3, 0, 8'h00, 0, 0, 1, 0);
      push(8, 9, 0, 3, 0, 8'h00, 0, 0, 0, 0);
      run_seq("min_params", 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dphy_tx_lane_seq.md
# dphy_tx_lane_seq

Byte-level D-PHY HS transmit sequencer for one data lane, the transmit-side counterpart of the CSI-2 receiver's lane byte aligner. It accepts packet bytes on a valid/ready stream and drives the lane through the full burst sequence: LP-11 to LP-01, then LP-00, then HS-zero, the 0xB8 sync byte, the payload, HS-trail, and back to LP-11. Its outputs feed an external LSB-first 8:1 serializer and the LP line drivers.

## Interface
- LP01_CYCLES, 4: cycles lp_o is held at 2'b01; minimum 1.
- LP00_CYCLES, 6: cycles lp_o is held at 2'b00 before HS drive; minimum 1.
- HS_ZERO_BYTES, 8: 0x00 bytes sent before sync; minimum 1.
- TRAIL_BYTES, 4: HS-trail bytes sent after the last payload byte; minimum 1.
- clk_i  in  1  byte clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- s_valid_i  in  1  payload byte valid; also the burst request when idle.
- s_data_i  in  8  payload byte; bit 0 goes on the wire first.
- s_last_i  in  1  marks the final byte of the packet.
- s_ready_o  out  1  payload byte accepted when s_valid_i and s_ready_o are both high.
- hs_en_o  out  1  HS driver enable; hs_byte_o is meaningful only when this is high.
- hs_byte_o  out  8  byte to the serializer.
- lp_o  out  2  LP line state {Dp, Dn}.
- busy_o  out  1  high whenever the state is not IDLE.
- packet_done_o  out  1  one-cycle pulse when the burst ends.
- underflow_o  out  1  one-cycle pulse when the payload is starved.

## Operation
- States: IDLE, LP01, LP00, HS_ZERO, SYNC, PAYLOAD, TRAIL, EXIT.
- IDLE: lp=11, hs_en=0. On s_valid_i, go to LP01. s_data_i is not consumed.
- LP01 and LP00: one shared down-counter, width $clog2 of the largest parameter plus 1. The state advances when the count expires.
- LP00 to HS_ZERO: hs_en rises and the lane sends 0x00 for HS_ZERO_BYTES cycles.
- SYNC: sends 0xB8 for one cycle. s_ready_o is asserted in this cycle, so the first payload byte can already be accepted here.
- PAYLOAD: each accepted byte is sent unchanged.
  - s_last_i on an accepted byte moves the state to TRAIL and deasserts s_ready_o.
  - Bit 7 of every byte sent (sync or payload) is latched as last_bit.
- Underflow: s_valid_i low while s_ready_o is high (SYNC or PAYLOAD). The lane cannot pause, so:
  - underflow_o pulses;
  - the state goes to TRAIL without consuming anything;
  - any remaining bytes of that packet are left for the next request.
- TRAIL: sends {8{~last_bit}} for TRAIL_BYTES cycles. After an underflow at SYNC, last_bit comes from 0xB8, so the trail byte is 0x00.
- EXIT: hs_en=0, lp=11, packet_done_o pulses, then the state goes to IDLE.
  - IDLE lasts at least 1 cycle before the next request is sampled.
  - A request is therefore never honoured back-to-back with EXIT.
- lp_o is 2'b00 throughout HS_ZERO, SYNC, PAYLOAD and TRAIL.

## Timing
- All outputs are registered. The action decided in cycle t appears on hs_byte_o, hs_en_o and lp_o at t+1.
- An accepted payload byte appears on hs_byte_o one cycle after acceptance.
- s_ready_o comes straight from the state register and has no combinational path from s_valid_i.
- Latency from request (s_valid_i high in IDLE at cycle 0):
  - lp_o=01 in cycles 1..LP01_CYCLES;
  - lp_o=00 for the next LP00_CYCLES cycles;
  - then HS_ZERO_BYTES zeros;
  - then 0xB8.
  - With defaults: lp 01 in cycles 1-4, lp 00 in cycles 5-10, hs_en and zeros in cycles 11-18, 0xB8 at 19, first payload at 20.
- Reset values, applied immediately on rst_n_i low at any point, including mid-burst:
  - state=IDLE, lp_o=2'b11, hs_en_o=0, hs_byte_o=0x00;
  - s_ready_o=0, busy_o=0, packet_done_o=0, underflow_o=0;
  - counters and last_bit=0.
- After rst_n_i deasserts, the first request is sampled on the first clock edge.
- s_valid_i and s_last_i have no effect outside SYNC, PAYLOAD and IDLE.

## Test plan
- 3-byte packet 0x11, 0x22, 0x93 (last), defaults, valid held high from cycle 0:
  - lp 01 in cycles 1-4, lp 00 in cycles 5-10;
  - hs_byte 0x00 in cycles 11-18, 0xB8 at 19, then 0x11, 0x22, 0x93 in cycles 20-22;
  - trail 0x00 in cycles 23-26 (bit 7 of 0x93 is 1);
  - cycle 27: hs_en=0, lp=11, packet_done pulse.
- Last byte 0x7F: trail bytes are 0xFF × TRAIL_BYTES.
- s_valid_i dropped after 2 of 5 bytes:
  - underflow_o pulses exactly once;
  - trail is the inverse of bit 7 of the 2nd byte;
  - packet_done pulses and there are no hangs.
- Two requests back-to-back (valid held high after last):
  - at least one IDLE cycle with lp=11 between EXIT and the next LP01;
  - the second burst's timeline is identical to the first.
- rst_n_i pulsed low during PAYLOAD, asynchronously between clock edges:
  - outputs take their reset values before the next edge;
  - a fresh packet after release completes normally.
- All parameters set to 1 and a 1-byte packet 0x00: exactly 1 cycle each of LP01, LP00, zero, sync and payload, then trail 0xFF for 1 cycle.
